gray_stream_checker: RTL

Receive-side companion to the Gray code generator. It takes a qualified stream of Gray code words, converts each one to binary, and checks that consecutive words form a valid +1 sequence (modulo 2^DATA_WIDTH). It reports lock status, per-sample step errors, and a saturating error count. It sits directly downstream of the Gray counter or any Gray-coded source.

---
 rtl/gray_stream_checker_if.sv | 25 ++
 rtl/gray_stream_checker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gray_stream_checker_if.sv
// Stream bundle between a Gray-coded source and the checker: sample inputs
// plus the decoded/status outputs.
interface gray_stream_checker_if #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
);
    logic                     in_valid;
    logic [DATA_WIDTH-1:0]    in_gray;
    logic                     clear_err;
    logic                     out_valid;
    logic [DATA_WIDTH-1:0]    out_bin;
    logic                     locked;
    logic                     step_err;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output in_valid, in_gray, clear_err,
        input  out_valid, out_bin, locked, step_err, err_count
    );

    modport slave (
        input  in_valid, in_gray, clear_err,
        output out_valid, out_bin, locked, step_err, err_count
    );
endinterface

// File: rtl/gray_stream_checker.sv
// Decodes a Gray-coded sample stream and checks it advances by +1 per sample,
// reporting lock, per-sample step errors and a saturating error count.
module gray_stream_checker #(
    parameter int unsigned DATA_WIDTH    = 4,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    gray_stream_checker_if.slave bus
);
    localparam int unsigned CNT_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_good_cnt;
    logic [CNT_W-1:0]         w_good_cnt_nxt;
    logic [DATA_WIDTH-1:0]    r_bin;
    logic [DATA_WIDTH-1:0]    w_dec;
    logic [DATA_WIDTH-1:0]    w_prev_inc;
    logic                     w_good;
    logic                     r_out_valid;
    logic                     r_step_err;
    logic                     w_step_err_nxt;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic [ERR_CNT_WIDTH-1:0] w_err_count_nxt;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        w_dec = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            w_dec[i] = ^(bus.in_gray >> i);
        end
    end

    assign w_prev_inc = r_bin + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign w_good     = (w_dec == w_prev_inc);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ACQUIRE;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        if (bus.in_valid) begin
            case (r_state)
                ACQUIRE: begin
                    w_state_nxt    = TRACK;
                    w_good_cnt_nxt = '0;
                end
                TRACK: begin
                    if (w_good) begin
                        w_good_cnt_nxt = r_good_cnt + 1'b1;
                        if (r_good_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                            w_state_nxt = LOCKED;
                        end
                    end else begin
                        w_good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!w_good) begin
                        w_state_nxt    = TRACK;
                        w_good_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = ACQUIRE;
                    w_good_cnt_nxt = '0;
                end
            endcase
        end
    end

    // clear_err wins over a coincident increment.
    always_comb begin
        w_step_err_nxt  = bus.in_valid && (r_state == LOCKED) && !w_good;
        w_err_count_nxt = r_err_count;
        if (bus.clear_err) begin
            w_err_count_nxt = '0;
        end else if (w_step_err_nxt && (r_err_count != '1)) begin
            w_err_count_nxt = r_err_count + 1'b1;
        end
    end

    // r_bin doubles as prev_bin and the held out_bin: both track the last sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_bin       <= '0;
            r_step_err  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            r_step_err  <= w_step_err_nxt;
            r_err_count <= w_err_count_nxt;
            if (bus.in_valid) begin
                r_bin <= w_dec;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_bin   = r_bin;
    assign bus.locked    = (r_state == LOCKED);
    assign bus.step_err  = r_step_err;
    assign bus.err_count = r_err_count;
endmodule
